rd_port_arbiter: RTL
====================

# rd_port_arbiter

Round-robin arbiter that shares the single read port of the gray-code async FIFO among `NUM_REQ` consumers in the read clock domain. It sequences single-word reads toward the FIFO read controller: active-low `rd_req_` strobe in, `rd_valid`/data back. It steers each returned word to the granted consumer and limits each grant to a bounded burst. It sits between the consumer logic and the FIFO read side and owns the read-request line exclusively.

## Interface
- `NUM_REQ`, 4: number of consumers, 2..8.
- `DATA_WIDTH`, 8: FIFO word width.
- `MAX_BURST`, 4: maximum words per grant, 1..16.
- `TIMEOUT`, 15: cycles allowed in WAIT before abort (used only with `ARB_TIMEOUT_EN`), 1..255.

Ports:
- `rd_clk` in 1: read-domain clock; the only clock.
- `rst_` in 1: synchronous, active-low reset.
- `req` in NUM_REQ: level request per consumer, active-high.
- `gnt` out NUM_REQ: registered one-hot grant.
- `fifo_rd_req_` out 1: active-low read strobe to the FIFO read controller; one low cycle per word.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_valid` in 1: FIFO returned-data strobe.
- `fifo_rd_data` in DATA_WIDTH: FIFO read data.
- `out_valid` out NUM_REQ: registered per-consumer data strobe.
- `out_data` out DATA_WIDTH: registered data, shared by all consumers.
- `err` out 1: one-cycle timeout abort pulse.

## Operation
- Reset values:
  - `gnt`=0, `fifo_rd_req_`=1, `out_valid`=0, `out_data`=0, `err`=0.
  - State IDLE, `beat_cnt`=0.
  - RR pointer `last`=NUM_REQ-1, so consumer 0 wins first.
- IDLE:
  - If `|req && !fifo_empty`, the winner is the first set `req` bit searching `last+1, last+2, …` modulo NUM_REQ.
  - Set `gnt` to the winner, clear `beat_cnt`, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: drive `fifo_rd_req_`=0 for exactly this cycle, go to WAIT.
- WAIT:
  - `fifo_rd_req_`=1.
  - On `fifo_rd_valid`: capture data and pulse `out_valid`, then `beat_cnt`++.
    - If `beat_cnt==MAX_BURST-1`, or `req[winner]==0`, or `fifo_empty`: go to RELEASE.
    - Otherwise go to ISSUE.
- RELEASE:
  - Clear `gnt`, set `last`=winner, go to IDLE.
  - A new grant is earliest on the following cycle.
- At most one word is outstanding at any time.
- `fifo_rd_valid` outside WAIT is ignored: no `out_valid`, no state change.
- A consumer dropping `req` in WAIT does not cancel the outstanding word. The word is still delivered, then the arbiter releases.
- `out_valid` is one-hot or zero, and is always a subset of the `gnt` of the cycle in which the data arrived.
- `beat_cnt` width is `$clog2(MAX_BURST)+1`. `last` width is `$clog2(NUM_REQ)`; it wraps NUM_REQ-1 → 0.

## Timing
- `req` → `gnt`: 1 cycle when IDLE and not empty.
- `gnt` rise → `fifo_rd_req_` low: 1 cycle (ISSUE).
- `fifo_rd_valid` at edge N → `out_valid`/`out_data` at N+1.
- Back-to-back beats: ISSUE → WAIT → ISSUE. Throughput is bounded by the FIFO's request-to-valid latency plus 1 cycle.
- Grant turnaround, consumer A → B: RELEASE + IDLE = 2 cycles without a strobe.
- Reset mid-burst: all outputs return to reset values at the first `rst_`-low edge. A late `fifo_rd_valid` after reset is dropped.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter is reset on entry to WAIT.
  - After `TIMEOUT` cycles in WAIT with no `fifo_rd_valid`: pulse `err` for 1 cycle, clear `gnt`, advance `last` to the winner, go to IDLE.
- Not defined: no counter exists, WAIT holds indefinitely, and `err` is tied to 0.

## Test plan
- Reset, `req`=4'b0001, FIFO holds 6 words → consumer 0 gets exactly 4 `out_valid[0]` pulses with data in FIFO order, `gnt` drops, and 2 cycles later it is re-granted for the remaining 2 words.
- `req`=4'b1111 held, FIFO never empty → grants rotate 0,1,2,3,0 with 4 words each; each grant carries 4 single-cycle `fifo_rd_req_` low pulses.
- `req`=4'b0110, `last`=1 → consumer 2 granted first, then consumer 1.
- Consumer 0 drops `req` after its first beat while word 2 is in flight → word 2 is delivered on `out_valid[0]`, then RELEASE; `beat_cnt` never reaches 3.
- `fifo_empty` asserts after beat 2 of 4 → release after beat 2. No strobe is issued while empty; IDLE waits for `fifo_empty`=0.
- `ARB_TIMEOUT_EN`, `TIMEOUT`=15, `fifo_rd_valid` suppressed after ISSUE → `err` pulses once on the 15th WAIT cycle, `gnt`=0 the next cycle, and a later stray `fifo_rd_valid` produces no `out_valid`.

Source files
------------

// File: rtl/rd_port_arbiter.sv
// rd_port_arbiter: round-robin arbiter sharing the async FIFO read port among NUM_REQ consumers.
// Latency: req->gnt 1 cycle, gnt->strobe same cycle (ISSUE), fifo_rd_valid->out_valid 1 cycle.
// Backpressure: one word outstanding; grant ends after MAX_BURST words, on req drop or FIFO empty.
// Optional feature macro: ARB_TIMEOUT_EN aborts a WAIT with no fifo_rd_valid after TIMEOUT cycles.
module rd_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  rd_clk,
  input  logic                  rst_,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  fifo_rd_req_,
  input  logic                  fifo_empty,
  input  logic                  fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic [CNT_W-1:0] beat_cnt;

`ifdef ARB_TIMEOUT_EN
  // Counts completed WAIT cycles without a returned word; TIMEOUT never exceeds 255.
  logic [7:0]       wait_cnt;
`else
  // No timeout logic in this build: constant low for every legal TIMEOUT.
  assign err = (TIMEOUT < 1);
`endif

  // Round-robin search: first requester after the previous winner, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req[IDX_W'((int'(last) + i) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(last) + i) % NUM_REQ);
      end
    end
  end

  // Arbitration FSM with registered grant, read strobe, data steering and error outputs.
  always_ff @(posedge rd_clk) begin
    if (!rst_) begin
      state        <= S_IDLE;
      last         <= IDX_W'(NUM_REQ - 1);
      winner       <= '0;
      beat_cnt     <= '0;
      gnt          <= '0;
      fifo_rd_req_ <= 1'b1;
      out_valid    <= '0;
      out_data     <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt     <= '0;
      err          <= 1'b0;
`endif
    end else begin
      out_valid <= '0;
`ifdef ARB_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found && !fifo_empty) begin
            winner       <= pick;
            gnt          <= NUM_REQ'(1) << pick;
            beat_cnt     <= '0;
            fifo_rd_req_ <= 1'b0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The strobe is low for exactly the ISSUE cycle.
          fifo_rd_req_ <= 1'b1;
          state        <= S_WAIT;
`ifdef ARB_TIMEOUT_EN
          wait_cnt     <= '0;
          err          <= (TIMEOUT == 1);
`endif
        end
        S_WAIT: begin
          if (fifo_rd_valid) begin
            out_valid <= gnt;
            out_data  <= fifo_rd_data;
            beat_cnt  <= beat_cnt + CNT_W'(1);
            // A dropped req still gets its in-flight word, then the grant ends.
            if (beat_cnt == CNT_W'(MAX_BURST - 1) || !req[winner] || fifo_empty) begin
              state <= S_RELEASE;
            end else begin
              fifo_rd_req_ <= 1'b0;
              state        <= S_ISSUE;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            // err was raised during this final WAIT cycle; drop the grant now.
            gnt   <= '0;
            last  <= winner;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            err      <= (wait_cnt == 8'(TIMEOUT - 2));
          end
`endif
        end
        S_RELEASE: begin
          gnt   <= '0;
          last  <= winner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
